// File: rtl/led_pkg.sv
// Shared FSM state type and mode encodings for the LED breathing driver.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_e;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with duty compare; counter can be frozen or cleared.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out,
    output logic                period_end
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= clr ? '0 : cnt + PWM_BITS'(1);
        end
    end

    assign pwm_out    = (cnt < duty);
    assign period_end = (cnt == '1);

endmodule

// File: rtl/led_breathe.sv
// LED driver: off, steady on, or triangular breathing PWM with a per-breath done pulse.
module led_breathe
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_PERIODS = 122,
    parameter int unsigned HOLD_STEPS   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                freeze,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic                cycle_done
);

    localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [STEP_W-1:0]   step_cnt, step_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [1:0]          mode_q, mode_d;
    logic                led_q, led_d;
    logic                done_q, done_d;
    logic                run, mode_chg, enter, pb, se;
    logic                pwm_out, period_end;

    assign run      = !freeze;
    assign mode_chg = (mode != mode_q);
    assign enter    = mode_chg && (mode == MODE_BREATHE);
    // A period boundary is only consumed on a running cycle that is not a restart.
    assign pb       = run && !enter && period_end;
    assign se       = pb && (step_cnt == STEP_LAST);

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (run),
        .clr       (enter),
        .duty      (duty_q),
        .pwm_out   (pwm_out),
        .period_end(period_end)
    );

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        step_d  = step_cnt;
        hold_d  = hold_cnt;
        mode_d  = mode_q;
        led_d   = led_q;
        done_d  = 1'b0;

        if (run) begin
            mode_d = mode;
            case (mode)
                MODE_OFF:     led_d = 1'b0;
                MODE_ON:      led_d = 1'b1;
                MODE_BREATHE: led_d = pwm_out;
                default:      led_d = 1'b0;
            endcase

            if (enter) begin
                state_d = UP;
                duty_d  = '0;
                step_d  = '0;
                hold_d  = '0;
            end else begin
                if (pb) begin
                    step_d = (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
                end

                if (mode_chg) begin
                    state_d = IDLE;
                    duty_d  = '0;
                end else if (se) begin
                    case (state_q)
                        UP: begin
                            if (duty_q != DUTY_MAX) begin
                                duty_d = duty_q + PWM_BITS'(1);
                            end
                            if (duty_q >= DUTY_MAX - PWM_BITS'(1)) begin
                                state_d = HOLD_HI;
                                hold_d  = '0;
                            end
                        end
                        HOLD_HI: begin
                            if (hold_cnt == HOLD_LAST) begin
                                state_d = DOWN;
                                hold_d  = '0;
                            end else begin
                                hold_d = hold_cnt + HOLD_W'(1);
                            end
                        end
                        DOWN: begin
                            if (duty_q != '0) begin
                                duty_d = duty_q - PWM_BITS'(1);
                            end
                            if (duty_q <= PWM_BITS'(1)) begin
                                state_d = HOLD_LO;
                                hold_d  = '0;
                            end
                        end
                        HOLD_LO: begin
                            if (hold_cnt == HOLD_LAST) begin
                                state_d = UP;
                                hold_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                hold_d = hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            duty_d  = '0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            mode_q   <= MODE_OFF;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            step_cnt <= step_d;
            hold_cnt <= hold_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    assign led        = led_q;
    assign duty       = duty_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: time-based reference model of the breathing pattern.
module tb_led_breathe;

    localparam int PB   = 3;
    localparam int P    = 8;
    localparam int S    = 2;
    localparam int H    = 2;
    localparam int MAXD = 7;
    localparam int T    = P * S;
    localparam int L    = 2 * MAXD + 2 * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       freeze;
    logic       led;
    logic [2:0] duty;
    logic       cycle_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: t counts running edges since breathing was entered.
    int         t;
    bit         br;
    logic [1:0] mq;
    logic       m_led;
    logic [2:0] m_duty;
    logic       m_done;

    led_breathe #(
        .PWM_BITS    (PB),
        .STEP_PERIODS(S),
        .HOLD_STEPS  (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .freeze    (freeze),
        .led       (led),
        .duty      (duty),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int duty_at(int tt);
        int m;
        m = (tt / T) % L;
        if (m <= MAXD) return m;
        if (m <= MAXD + H) return MAXD;
        if (m <= 2 * MAXD + H) return MAXD - (m - MAXD - H);
        return 0;
    endfunction

    task automatic model_reset();
        t = 0; br = 0; mq = 2'b00;
        m_led = 1'b0; m_duty = 3'd0; m_done = 1'b0;
    endtask

    task automatic tick();
        logic led_n;
        int   phase;
        @(posedge clk);
        if (rst_n && !freeze) begin
            phase = t % P;
            if (mode == 2'b01) led_n = 1'b1;
            else if (mode == 2'b10 && br) led_n = (phase < int'(m_duty));
            else led_n = 1'b0;
            if (mode != mq) begin
                br = (mode == 2'b10);
                t  = 0;
            end else if (br) begin
                t++;
            end
            mq     = mode;
            m_duty = br ? 3'(duty_at(t)) : 3'd0;
            m_done = br && (t > 0) && ((t % (L * T)) == 0);
            m_led  = led_n;
        end else if (rst_n) begin
            m_done = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; mode = 2'b00; freeze = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({led, duty, cycle_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", {led, duty, cycle_done}, 5'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_tests++;
        if ({led, duty, cycle_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", {led, duty, cycle_done}, 5'b0);
        end
    endtask

    task automatic test_on_off();
        logic [1:0] seq [3] = '{2'b01, 2'b00, 2'b11};
        for (int s = 0; s < 3; s++) begin
            mode = seq[s];
            for (int k = 0; k < 4; k++) begin
                tick();
                n_tests++;
                if ({led, duty, cycle_done} !== {m_led, m_duty, m_done}) begin
                    n_fail++;
                    $display("FAIL on_off mode=%b k=%0d: got %b want %b", mode, k,
                             {led, duty, cycle_done}, {m_led, m_duty, m_done});
                end
            end
        end
    endtask

    task automatic test_ramp();
        int done_at [$];
        mode = 2'b00; tick();
        mode = 2'b10; tick();
        for (int k = 1; k <= 600; k++) begin
            tick();
            n_tests++;
            if ({led, duty, cycle_done} !== {m_led, m_duty, m_done}) begin
                n_fail++;
                $display("FAIL ramp k=%0d: got %b want %b", k,
                         {led, duty, cycle_done}, {m_led, m_duty, m_done});
            end
            if (cycle_done) done_at.push_back(k);
            if (k == 111 || k == 112) begin
                n_tests++;
                if (duty !== ((k == 112) ? 3'd7 : 3'd6)) begin
                    n_fail++;
                    $display("FAIL ramp_top k=%0d: got %0d want %0d", k, duty, (k == 112) ? 7 : 6);
                end
            end
        end
        n_tests++;
        if (done_at.size() != 2 || done_at[0] != 288 || done_at[1] != 576) begin
            n_fail++;
            $display("FAIL cycle_done_times: got %0d pulses (first %0d) want 2 at 288,576",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
    endtask

    task automatic test_duty_pwm();
        logic [7:0] pat;
        mode = 2'b00; tick();
        mode = 2'b10; tick();
        for (int k = 1; k <= 48; k++) tick();
        n_tests++;
        if (duty !== 3'd3) begin
            n_fail++;
            $display("FAIL duty3_reached: got %0d want 3", duty);
        end
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pat[k] = led;
        end
        n_tests++;
        if (pat !== 8'b0000_0111) begin
            n_fail++;
            $display("FAIL pwm_pattern: got %b want %b", pat, 8'b0000_0111);
        end
    endtask

    task automatic test_freeze();
        mode = 2'b00; tick();
        mode = 2'b10; tick();
        for (int k = 1; k <= 170; k++) tick();
        freeze = 1'b1;
        for (int k = 0; k < 50; k++) begin
            mode = (k % 7 == 3) ? 2'b01 : 2'($urandom_range(0, 3));
            tick();
            n_tests++;
            if ({led, duty, cycle_done} !== {m_led, m_duty, m_done} || duty !== 3'd6) begin
                n_fail++;
                $display("FAIL freeze_hold k=%0d: got %b want %b", k,
                         {led, duty, cycle_done}, {m_led, 3'd6, 1'b0});
            end
        end
        mode = 2'b01;
        freeze = 1'b0;
        tick();
        n_tests++;
        if ({led, duty, cycle_done} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL freeze_release: got %b want %b", {led, duty, cycle_done}, 5'b10000);
        end
    endtask

    task automatic test_random();
        mode = 2'b00; tick();
        mode = 2'b10;
        for (int k = 0; k < 2000; k++) begin
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 99) == 0) mode = 2'b10;
            tick();
            n_tests++;
            if ({led, duty, cycle_done} !== {m_led, m_duty, m_done}) begin
                n_fail++;
                $display("FAIL random k=%0d: got %b want %b", k,
                         {led, duty, cycle_done}, {m_led, m_duty, m_done});
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; tick();
        mode = 2'b10; tick();
        for (int k = 1; k <= 130; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({led, duty, cycle_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want %b", {led, duty, cycle_done}, 5'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_tests++;
            if ({led, duty, cycle_done} !== {m_led, m_duty, m_done}) begin
                n_fail++;
                $display("FAIL restart k=%0d: got %b want %b", k,
                         {led, duty, cycle_done}, {m_led, m_duty, m_done});
            end
        end
        n_tests++;
        if (duty !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_first_step: got %0d want 1", duty);
        end
    endtask

    initial begin
        test_reset();
        test_on_off();
        test_ramp();
        test_duty_pwm();
        test_freeze();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
